// File: rtl/dma_pcie_h2c_st_chk.sv
// dma_pcie_h2c_st_chk: QDMA H2C 512-bit AXI-Stream sink with pattern, length, keep, qid and optional parity checking plus statistics
// Ports: axi_aclk/axi_aresetn clock and async active-low reset; s_axis_h2c_* stream slave
// (tready registered, optionally throttled); chk_en/bp_en/clr_stats controls; pkt_cnt, byte_cnt,
// err_cnt, err_flags, last_err_qid statistics outputs.
// Optional macro DMA_H2C_CHK_PARITY_EN enables per-byte tparity checking (err_flags[0]).
module dma_pcie_h2c_st_chk #(
  parameter int BYTE_CNT_W = 48,
  parameter int BP_PERIOD  = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic [511:0]          s_axis_h2c_tdata,
  input  logic [63:0]           s_axis_h2c_tparity,
  input  logic                  s_axis_h2c_tlast,
  input  logic                  s_axis_h2c_tvalid,
  input  logic [63:0]           s_axis_h2c_tkeep,
  input  logic [31:0]           s_axis_h2c_tusr,
  output logic                  s_axis_h2c_tready,
  input  logic                  chk_en,
  input  logic                  bp_en,
  input  logic                  clr_stats,
  output logic [31:0]           pkt_cnt,
  output logic [BYTE_CNT_W-1:0] byte_cnt,
  output logic [15:0]           err_cnt,
  output logic [4:0]            err_flags,
  output logic [10:0]           last_err_qid
);
  localparam int CW = (BP_PERIOD > 2) ? $clog2(BP_PERIOD) : 1;
  typedef enum logic {SOP, MOP} state_t;
  state_t state;
  logic [CW-1:0] bp_cnt, bp_nxt;
  logic [15:0] off_q, len_q, off_cur, len_cur, end_off, exp_w;
  logic [10:0] qid_q, qid_cur, s1_qid;
  logic [4:0] acc_q, beat_err, perr, s1_err, s1_perr;
  logic [6:0] pc, s1_cnt;
  logic acc, first, data_bad, par_bad, keep_bad, s1_vld, s1_last, unused_bits;

  function automatic logic [6:0] popcnt(input logic [63:0] k);
    popcnt = '0;
    for (int i = 0; i < 64; i++) popcnt = popcnt + 7'(k[i]);
  endfunction

  assign acc     = s_axis_h2c_tvalid & s_axis_h2c_tready;
  assign first   = state == SOP;
  assign off_cur = first ? 16'd0 : off_q;
  assign len_cur = first ? s_axis_h2c_tusr[31:16] : len_q;
  assign qid_cur = first ? s_axis_h2c_tusr[10:0] : qid_q;
  assign pc      = popcnt(s_axis_h2c_tkeep);
  assign end_off = off_cur + 16'(pc);
  assign bp_nxt  = (bp_cnt == CW'(BP_PERIOD - 1)) ? '0 : bp_cnt + 1'b1;

  // Last beat may be partial but must be a non-empty run of ones starting at byte 0.
  assign keep_bad = s_axis_h2c_tlast
    ? (s_axis_h2c_tkeep == '0) || ((s_axis_h2c_tkeep & (s_axis_h2c_tkeep + 64'd1)) != '0)
    : (s_axis_h2c_tkeep != '1);

  // Word j of the beat carries (byte offset / 2 + j); only enabled bytes are compared.
  always_comb begin
    data_bad = 1'b0;
    exp_w = '0;
    for (int j = 0; j < 32; j++) begin
      exp_w = {1'b0, off_cur[15:1]} + 16'(j);
      if (s_axis_h2c_tkeep[2*j] && s_axis_h2c_tdata[16*j +: 8] != exp_w[7:0]) data_bad = 1'b1;
      if (s_axis_h2c_tkeep[2*j+1] && s_axis_h2c_tdata[16*j+8 +: 8] != exp_w[15:8]) data_bad = 1'b1;
    end
  end

`ifdef DMA_H2C_CHK_PARITY_EN
  always_comb begin
    par_bad = 1'b0;
    for (int i = 0; i < 64; i++)
      if (s_axis_h2c_tkeep[i] && s_axis_h2c_tparity[i] != ((^s_axis_h2c_tdata[8*i +: 8]) ^ (PARITY_ODD != 0)))
        par_bad = 1'b1;
  end
  assign unused_bits = ^s_axis_h2c_tusr[15:11];
`else
  assign par_bad = 1'b0;
  assign unused_bits = ^{s_axis_h2c_tusr[15:11], s_axis_h2c_tparity};
`endif

  // A length field of 0 encodes 65536, which is 0 in the 16-bit offset arithmetic.
  assign beat_err = {!first && s_axis_h2c_tusr[10:0] != qid_q,
                     chk_en && data_bad,
                     chk_en && s_axis_h2c_tlast && end_off != len_cur,
                     keep_bad,
                     par_bad};
  assign perr = beat_err | (first ? 5'd0 : acc_q);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state <= SOP;
      bp_cnt <= '0;
      s_axis_h2c_tready <= 1'b0;
      off_q <= '0;
      len_q <= '0;
      qid_q <= '0;
      acc_q <= '0;
      s1_vld <= 1'b0;
      s1_last <= 1'b0;
      s1_cnt <= '0;
      s1_err <= '0;
      s1_perr <= '0;
      s1_qid <= '0;
      pkt_cnt <= '0;
      byte_cnt <= '0;
      err_cnt <= '0;
      err_flags <= '0;
      last_err_qid <= '0;
    end else begin
      bp_cnt <= bp_nxt;
      s_axis_h2c_tready <= !(bp_en && bp_nxt == CW'(BP_PERIOD - 1));
      s1_vld <= acc;
      if (acc) begin
        state <= s_axis_h2c_tlast ? SOP : MOP;
        off_q <= end_off;
        len_q <= len_cur;
        qid_q <= qid_cur;
        acc_q <= perr;
        s1_last <= s_axis_h2c_tlast;
        s1_cnt <= pc;
        s1_err <= beat_err;
        s1_perr <= perr;
        s1_qid <= qid_cur;
      end
      if (clr_stats) begin
        pkt_cnt <= '0;
        byte_cnt <= '0;
        err_cnt <= '0;
        err_flags <= '0;
        last_err_qid <= '0;
      end else if (s1_vld) begin
        byte_cnt <= byte_cnt + BYTE_CNT_W'(s1_cnt);
        err_flags <= err_flags | s1_err;
        if (s1_last) begin
          pkt_cnt <= pkt_cnt + 32'd1;
          if (|s1_perr) begin
            err_cnt <= (err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
            last_err_qid <= s1_qid;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dma_pcie_h2c_st_chk.sv
// tb_dma_pcie_h2c_st_chk: directed table-driven bench for the H2C stream checker
module tb_dma_pcie_h2c_st_chk;
  logic axi_aclk = 1'b0;
  logic axi_aresetn = 1'b0;
  logic [511:0] tdata = '0;
  logic [63:0] tparity = '0, tkeep = '0;
  logic tlast = 1'b0, tvalid = 1'b0, tready;
  logic [31:0] tusr = '0;
  logic chk_en = 1'b1, bp_en = 1'b0, clr_stats = 1'b0;
  logic [31:0] pkt_cnt;
  logic [47:0] byte_cnt;
  logic [15:0] err_cnt;
  logic [4:0] err_flags;
  logic [10:0] last_err_qid;
  int total = 0, passed = 0;

`ifdef DMA_H2C_CHK_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  dma_pcie_h2c_st_chk dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .s_axis_h2c_tdata(tdata), .s_axis_h2c_tparity(tparity), .s_axis_h2c_tlast(tlast),
    .s_axis_h2c_tvalid(tvalid), .s_axis_h2c_tkeep(tkeep), .s_axis_h2c_tusr(tusr),
    .s_axis_h2c_tready(tready), .chk_en(chk_en), .bp_en(bp_en), .clr_stats(clr_stats),
    .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt), .err_cnt(err_cnt), .err_flags(err_flags),
    .last_err_qid(last_err_qid)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct {
    int nb;
    logic [63:0] lk;
    logic [15:0] len;
    logic [10:0] qid;
    int cw;
    bit ce;
    bit fp;
    logic [47:0] eb;
    logic [4:0] ef;
    logic [15:0] ee;
    logic [10:0] eq;
  } vec_t;
  vec_t v[8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    else passed++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge axi_aclk);
    #1;
  endtask

  task automatic clr();
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
  endtask

  task automatic load_beat(input int b, input int cw, input bit fp);
    logic [511:0] d;
    logic [63:0] p;
    for (int j = 0; j < 32; j++) d[16*j +: 16] = 16'(b * 32 + j);
    if (b == 0 && cw >= 0) d[16*cw +: 16] = 16'hDEAD;
    for (int i = 0; i < 64; i++) p[i] = ^d[8*i +: 8];
    if (fp) p[3] = ~p[3];
    tdata = d;
    tparity = p;
  endtask

  task automatic wait_acc();
    int g = 0;
    bit r;
    do begin
      r = tready;
      tick(1);
      g++;
    end while (!r && g < 32);
    if (!r) begin
      total++;
      $display("FAIL accept_timeout: got tready 0 expected 1");
    end
  endtask

  task automatic send_pkt(input logic [10:0] q, input logic [15:0] l, input int nb,
                          input logic [63:0] lk, input int cw, input bit fp);
    for (int b = 0; b < nb; b++) begin
      load_beat(b, cw, fp);
      tkeep = (b == nb - 1) ? lk : '1;
      tlast = (b == nb - 1);
      tusr = {l, 5'd0, q};
      tvalid = 1'b1;
      wait_acc();
    end
    tvalid = 1'b0;
    tlast = 1'b0;
  endtask

  initial begin
    int low, acc;
    v[0] = '{2, '1, 16'd128, 11'd5, -1, 1'b1, 1'b0, 48'd128, 5'd0, 16'd0, 11'd0};
    v[1] = '{2, 64'h0000000F_FFFFFFFF, 16'd100, 11'd9, -1, 1'b1, 1'b0, 48'd100, 5'd0, 16'd0, 11'd0};
    v[2] = '{2, 64'h0000000F_FFFFFFFF, 16'd96, 11'd9, -1, 1'b1, 1'b0, 48'd100, 5'd4, 16'd1, 11'd9};
    v[3] = '{2, '1, 16'd128, 11'd3, 7, 1'b1, 1'b0, 48'd128, 5'd8, 16'd1, 11'd3};
    v[4] = '{2, '1, 16'd128, 11'd3, 7, 1'b0, 1'b0, 48'd128, 5'd0, 16'd0, 11'd0};
    v[5] = '{1, '1, 16'd64, 11'd7, -1, 1'b1, 1'b1, 48'd64, PAR_ON ? 5'd1 : 5'd0,
             PAR_ON ? 16'd1 : 16'd0, PAR_ON ? 11'd7 : 11'd0};
    v[6] = '{1, 64'h5, 16'd2, 11'd2, -1, 1'b1, 1'b0, 48'd2, 5'd2, 16'd1, 11'd2};
    v[7] = '{1024, '1, 16'd0, 11'd1, -1, 1'b1, 1'b0, 48'd65536, 5'd0, 16'd0, 11'd0};

    tick(3);
    chk("reset_tready", tready, 0);
    chk("reset_pkt_cnt", pkt_cnt, 0);
    chk("reset_byte_cnt", byte_cnt, 0);
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_err_flags", err_flags, 0);
    axi_aresetn = 1'b1;
    tick(1);
    chk("tready_after_reset", tready, 1);

    foreach (v[k]) begin
      clr();
      chk_en = v[k].ce;
      send_pkt(v[k].qid, v[k].len, v[k].nb, v[k].lk, v[k].cw, v[k].fp);
      tick(2);
      $display("vector %0d", k);
      chk("pkt_cnt", pkt_cnt, 1);
      chk("byte_cnt", byte_cnt, v[k].eb);
      chk("err_flags", err_flags, v[k].ef);
      chk("err_cnt", err_cnt, v[k].ee);
      chk("last_err_qid", last_err_qid, v[k].eq);
    end
    chk_en = 1'b1;

    clr();
    load_beat(0, -1, 1'b0);
    tkeep = '1;
    tlast = 1'b1;
    tusr = {16'd64, 5'd0, 11'd0};
    bp_en = 1'b1;
    tick(2);
    low = 0;
    acc = 0;
    tvalid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (tready) acc++;
      else low++;
      tick(1);
    end
    tvalid = 1'b0;
    tlast = 1'b0;
    bp_en = 1'b0;
    tick(2);
    chk("bp_low_cycles", low, 4);
    chk("bp_accepted", acc, 60);
    chk("bp_byte_cnt", byte_cnt, 3840);
    chk("bp_pkt_cnt", pkt_cnt, 60);
    chk("bp_err_cnt", err_cnt, 0);

    clr();
    send_pkt(11'd6, 16'd64, 1, '1, -1, 1'b0);
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
    tick(2);
    chk("clr_wins_pkt_cnt", pkt_cnt, 0);
    chk("clr_wins_byte_cnt", byte_cnt, 0);

    load_beat(0, -1, 1'b0);
    tkeep = '1;
    tlast = 1'b0;
    tusr = {16'd192, 5'd0, 11'd8};
    tvalid = 1'b1;
    wait_acc();
    tvalid = 1'b0;
    axi_aresetn = 1'b0;
    #1;
    chk("midpkt_reset_tready", tready, 0);
    tick(2);
    chk("midpkt_reset_tready_held", tready, 0);
    axi_aresetn = 1'b1;
    tick(1);
    send_pkt(11'd4, 16'd64, 1, '1, -1, 1'b0);
    tick(2);
    chk("post_reset_pkt_cnt", pkt_cnt, 1);
    chk("post_reset_byte_cnt", byte_cnt, 64);
    chk("post_reset_err_flags", err_flags, 0);
    chk("post_reset_err_cnt", err_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dma_pcie_h2c_st_chk.md
Name: dma_pcie_h2c_st_chk

Overview:
- Sink-side consumer of the 512-bit QDMA H2C AXI-Stream (master modport of the H2C stream interface drives this block's slave side).
- Accepts packets and checks per-byte parity, tkeep legality, packet length against tusr, and the incrementing 16-bit data pattern.
- Keeps packet, byte and error statistics for the example design's register file.
- Optionally throttles tready to exercise upstream backpressure.

Parameters:
- BYTE_CNT_W, 48, width of the accepted-byte counter
- BP_PERIOD, 16, cycle period of the throttle window (>=2)
- PARITY_ODD, 0, 0 = even parity (tparity[i] = ^tdata byte i); 1 = odd parity (inverted)

Ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  async active-low reset
- s_axis_h2c_tdata  in  512  stream data
- s_axis_h2c_tparity  in  64  per-byte parity
- s_axis_h2c_tlast  in  1  end of packet
- s_axis_h2c_tvalid  in  1  beat valid
- s_axis_h2c_tkeep  in  64  byte enables
- s_axis_h2c_tusr  in  32  [10:0] qid, [15:11] reserved, [31:16] packet length in bytes (sampled on first beat)
- s_axis_h2c_tready  out  1  beat ready
- chk_en  in  1  enable pattern/length checks
- bp_en  in  1  enable tready throttling
- clr_stats  in  1  single-cycle pulse; clears counters and sticky flags
- pkt_cnt  out  32  good and bad packets completed
- byte_cnt  out  BYTE_CNT_W  accepted bytes (popcount tkeep)
- err_cnt  out  16  packets with at least one error (saturating)
- err_flags  out  5  sticky: [0] parity, [1] keep, [2] length, [3] data, [4] qid change mid-packet
- last_err_qid  out  11  qid of the most recent erroneous packet

Behaviour:
- Reset: all outputs 0, including tready. tready goes to 1 on the first clock edge after axi_aresetn deasserts, unless throttled.
- A beat is accepted when tvalid && tready. No combinational path from tvalid to tready.
- Throttle:
  - A free-running counter wraps at BP_PERIOD-1.
  - With bp_en=1, tready=0 in the cycle the counter equals BP_PERIOD-1; otherwise tready=1.
  - The counter runs during packets and is reset only by reset.
- FSM:
  - SOP: first beat accepted -> latch qid and length, clear packet offset and error vector. Go to MOP, or stay in SOP if tlast is set.
  - MOP: accept beats; tlast -> SOP.
  - Reset mid-packet returns to SOP, discarding partial state.
- Offset: the packet byte offset advances by popcount(tkeep) per beat, 16-bit arithmetic, wraps at 65536.
- Checks (each accepted beat):
  - Keep: tkeep must be all-ones on non-last beats. On the last beat it must be contiguous from bit 0 and non-zero. Violation sets keep error.
  - Data (chk_en=1): every enabled 16-bit word j must equal (offset/2 + j) mod 65536. Odd lengths compare only the enabled low byte.
  - Length (chk_en=1): on tlast, offset + popcount != latched length (mod 65536) -> length error. A length field of 0 means 65536.
  - qid: tusr[10:0] differing from the latched qid on a non-first beat -> qid error.
- Pipeline:
  - Stage 1 registers the beat and compare results.
  - Stage 2 updates byte_cnt, err_flags and, on the last beat, pkt_cnt, err_cnt and last_err_qid.
  - Counters reflect a beat accepted at cycle N at cycle N+2.
- Counters: pkt_cnt and byte_cnt wrap; err_cnt saturates at 0xFFFF.
- clr_stats coinciding with a stage-2 update: the clear wins and that update is dropped. Checking of the in-flight packet continues.
- chk_en=0: only keep, qid and parity (if compiled in) errors are recorded.

Optional Feature:
- Macro DMA_H2C_CHK_PARITY_EN.
- Defined: each enabled byte's tparity bit is compared per PARITY_ODD; any mismatch sets err_flags[0] and marks the packet erroneous.
- Undefined: tparity is ignored, err_flags[0] is tied 0, and no parity logic is synthesized.

Test Plan:
- Single 128-byte packet, qid=5, len=128, correct pattern, 2 full beats, bp_en=0 -> pkt_cnt=1, byte_cnt=128, err_cnt=0, err_flags=0, counters valid 2 cycles after last acceptance.
- 100-byte packet: beat 2 has tkeep=0x0000000F_FFFFFFFF; tusr length=100 -> no error. Same beat with length=96 -> err_flags[2]=1, err_cnt=1, last_err_qid=qid.
- Data word 7 of beat 1 corrupted to 0xDEAD, chk_en=1 -> err_flags[3]=1. Repeat with chk_en=0 -> err_flags=0.
- bp_en=1, BP_PERIOD=16, continuous tvalid for 64 cycles -> exactly 4 tready-low cycles, 60 beats accepted, byte_cnt=3840.
- With DMA_H2C_CHK_PARITY_EN, flip tparity[3] on a single-beat packet -> err_flags[0]=1, err_cnt=1. Without the macro -> no error.
- Assert axi_aresetn low mid-packet after beat 1 of 3, release, send a fresh 64-byte packet -> tready=0 during reset, pkt_cnt=1, byte_cnt=64, no errors.
